filter_sequencer: RTL

Sequencing controller for the polyphase pulse-shaping filter. It takes symbols from an upstream bit source through a valid/ready handshake. It generates the sample-rate strobe from a programmable clock divider and drives the filter's `i_bit`/`i_valid`/`i_enable` inputs, presenting each symbol for exactly OS consecutive filter phases. It also tracks the polyphase index, flags downstream when a filtered sample is ready, and detects symbol underrun.

---
 rtl/filter_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/filter_sequencer.sv
// filter_sequencer: feeds upstream symbols to the polyphase filter, one symbol per OS sample strobes.
// Optional FILTER_SEQ_PRBS_EN adds i_prbs_sel and an internal PRBS9 symbol source.
module filter_sequencer #(
    parameter int OS     = 4,
    parameter int NB_DIV = 8,
    parameter int NB_PH  = $clog2(OS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_enable,
    input  logic [NB_DIV-1:0] i_div,
    input  logic              i_bit,
    input  logic              i_bit_valid,
`ifdef FILTER_SEQ_PRBS_EN
    input  logic              i_prbs_sel,
`endif
    input  logic              i_clr_underrun,
    output logic              o_bit_ready,
    output logic              o_filt_bit,
    output logic              o_filt_valid,
    output logic              o_filt_enable,
    output logic [NB_PH-1:0]  o_phase,
    output logic              o_sample_valid,
    output logic              o_underrun
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t            state;
    logic [NB_DIV-1:0] cnt;
    logic              full;
    logic              buf_bit;
    logic              prbs_on;
    logic              prbs_bit;
    logic              hs;
    logic              tc;
    logic              boundary;
    logic              underrun_set;

`ifdef FILTER_SEQ_PRBS_EN
    logic [8:0] lfsr;

    assign prbs_on  = i_prbs_sel;
    assign prbs_bit = lfsr[8];

    // x^9 + x^5 + 1; symbol is the MSB, one advance per consumed symbol
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lfsr <= '1;
        else if (state == IDLE)
            lfsr <= '1;
        else if (prbs_on && i_enable && ((state == FILL) || boundary))
            lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
`else
    assign prbs_on  = 1'b0;
    assign prbs_bit = 1'b0;
`endif

    assign o_bit_ready   = ~prbs_on & ((state == FILL) | ((state == RUN) & ~full));
    assign o_filt_enable = (state == RUN);
    assign hs            = i_bit_valid & o_bit_ready;
    // exact compare: a count already past a lowered i_div runs on to all-ones and wraps
    assign tc            = (cnt == i_div);
    assign boundary      = o_filt_valid & (o_phase == NB_PH'(OS - 1));
    assign underrun_set  = i_enable & boundary & ~prbs_on & ~full & ~hs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            o_phase        <= '0;
            full           <= 1'b0;
            buf_bit        <= 1'b0;
            o_filt_bit     <= 1'b0;
            o_filt_valid   <= 1'b0;
            o_sample_valid <= 1'b0;
            o_underrun     <= 1'b0;
        end else begin
            o_sample_valid <= o_filt_valid;
            o_filt_valid   <= 1'b0;
            if (!i_enable) begin
                state   <= IDLE;
                cnt     <= '0;
                o_phase <= '0;
                full    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= FILL;
                    FILL: begin
                        if (prbs_on || hs) begin
                            o_filt_bit <= prbs_on ? prbs_bit : i_bit;
                            state      <= RUN;
                        end
                    end
                    RUN: begin
                        cnt          <= tc ? '0 : cnt + NB_DIV'(1);
                        o_filt_valid <= tc;
                        if (o_filt_valid)
                            o_phase <= o_phase + NB_PH'(1);
                        if (boundary) begin
                            if (prbs_on) begin
                                o_filt_bit <= prbs_bit;
                            end else if (full) begin
                                o_filt_bit <= buf_bit;
                                full       <= 1'b0;
                            end else begin
                                // same-cycle arrival bypasses the empty buffer
                                o_filt_bit <= hs ? i_bit : 1'b0;
                            end
                        end else if (hs) begin
                            buf_bit <= i_bit;
                            full    <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (underrun_set)
                o_underrun <= 1'b1;
            else if (i_clr_underrun)
                o_underrun <= 1'b0;
        end
    end

endmodule
